// File: rtl/morse_pkg.sv
// Shared types and sizing for the Morse decoder: FSM states, symbol limits and output widths.
package morse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MARK  = 2'd1,
      ST_SPACE = 2'd2
   } state_t;

   localparam int unsigned MAX_SYM = 5;
   localparam int unsigned LEN_W   = 3;
   localparam int unsigned BITS_W  = 5;
   localparam int unsigned DUR_W   = 3;
   localparam int unsigned DUR_MAX = (1 << DUR_W) - 1;
   localparam int unsigned SYM_W   = $clog2(MAX_SYM + 1);

   // Saturating increment for the tick-duration counter.
   function automatic logic [DUR_W-1:0] dur_inc(input logic [DUR_W-1:0] v);
      return (v == DUR_W'(DUR_MAX)) ? v : v + DUR_W'(1);
   endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Timing-tick prescaler: counts 0..TICK_DIV-1, ticks on the last count, restartable via clr.
module morse_tick_gen #(
   parameter int unsigned TICK_DIV = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst || clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/morse_decoder.sv
// Morse key decoder: times marks/spaces in ticks, collects dot/dash symbols and emits one code per character.
module morse_decoder
   import morse_pkg::*;
#(
   parameter int unsigned TICK_DIV = 10_000_000,
   parameter int unsigned DASH_MIN = 3,
   parameter int unsigned CHAR_GAP = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key,
   output logic              code_valid,
   output logic [LEN_W-1:0]  code_len,
   output logic [BITS_W-1:0] code_bits,
   output logic              overflow,
   output logic              busy
);

   state_t             state;
   logic               tick;
   logic [DUR_W-1:0]   dur;
   logic [DUR_W-1:0]   dur_eff;
   logic [SYM_W-1:0]   sym_cnt;
   logic [BITS_W-1:0]  sym_buf;
   logic               ovf;
   logic               is_dash;
   logic               go_mark;
   logic               go_space;
   logic               go_idle;
   logic               trans;

   // A tick landing on the release cycle still counts toward the mark length.
   assign dur_eff  = tick ? dur_inc(dur) : dur;
   assign is_dash  = 32'(dur_eff) >= DASH_MIN;

   assign go_mark  = key && (state == ST_IDLE || state == ST_SPACE);
   assign go_space = !key && (state == ST_MARK);
   assign go_idle  = !key && (state == ST_SPACE) && tick && (32'(dur) == CHAR_GAP - 1);
   assign trans    = go_mark || go_space || go_idle;

   morse_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (trans),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         dur        <= '0;
         sym_cnt    <= '0;
         sym_buf    <= '0;
         ovf        <= 1'b0;
         code_valid <= 1'b0;
         code_len   <= '0;
         code_bits  <= '0;
         overflow   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         code_valid <= 1'b0;
         overflow   <= 1'b0;
         busy       <= go_mark || (state != ST_IDLE && !go_idle);

         if (trans) begin
            dur <= '0;
         end else if (tick) begin
            dur <= dur_inc(dur);
         end

         case (state)
            ST_IDLE: begin
               if (key) begin
                  state <= ST_MARK;
               end
            end
            ST_MARK: begin
               if (!key) begin
                  state <= ST_SPACE;
                  if (sym_cnt < SYM_W'(MAX_SYM)) begin
                     sym_buf <= sym_buf | (BITS_W'(is_dash) << sym_cnt);
                     sym_cnt <= sym_cnt + SYM_W'(1);
                  end else begin
                     ovf <= 1'b1;
                  end
               end
            end
            ST_SPACE: begin
               if (key) begin
                  state <= ST_MARK;
               end else if (go_idle) begin
                  state <= ST_IDLE;
                  if (ovf) begin
                     overflow <= 1'b1;
                  end else begin
                     code_valid <= 1'b1;
                     code_len   <= LEN_W'(sym_cnt);
                     code_bits  <= sym_buf;
                  end
                  sym_buf <= '0;
                  sym_cnt <= '0;
                  ovf     <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder with TICK_DIV=4, DASH_MIN=3, CHAR_GAP=3.
module tb_morse_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       key;
   logic       code_valid;
   logic [2:0] code_len;
   logic [4:0] code_bits;
   logic       overflow;
   logic       busy;

   int passes = 0;
   int total  = 0;
   int valid_cnt = 0;
   int ovf_cnt   = 0;
   int v0;
   int o0;

   morse_decoder #(
      .TICK_DIV (4),
      .DASH_MIN (3),
      .CHAR_GAP (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key        (key),
      .code_valid (code_valid),
      .code_len   (code_len),
      .code_bits  (code_bits),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled on the falling edge
   always @(negedge clk) begin
      if (code_valid) valid_cnt = valid_cnt + 1;
      if (overflow)   ovf_cnt   = ovf_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passes = passes + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input logic v, input int n);
      key = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic mark_snap();
      v0 = valid_cnt;
      o0 = ovf_cnt;
   endtask

   initial begin
      rst = 1'b1;
      key = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(code_valid), 32'd0);
      chk("rst_len",   32'(code_len),   32'd0);
      chk("rst_bits",  32'(code_bits),  32'd0);
      chk("rst_ovf",   32'(overflow),   32'd0);
      chk("rst_busy",  32'(busy),       32'd0);
      rst = 1'b0;
      drive(1'b0, 3);

      // Letter A: dot then dash
      mark_snap();
      drive(1'b1, 4);
      chk("a_busy", 32'(busy), 32'd1);
      drive(1'b0, 4);
      drive(1'b1, 12);
      drive(1'b0, 16);
      chk("a_nvalid", 32'(valid_cnt - v0), 32'd1);
      chk("a_novf",   32'(ovf_cnt - o0),   32'd0);
      chk("a_len",    32'(code_len),       32'd2);
      chk("a_bits",   32'(code_bits),      32'h02);
      chk("a_idle",   32'(busy),           32'd0);

      // Dash threshold: 11 cycles is a dot
      mark_snap();
      drive(1'b1, 11);
      drive(1'b0, 16);
      chk("dot11_nvalid", 32'(valid_cnt - v0), 32'd1);
      chk("dot11_len",    32'(code_len),       32'd1);
      chk("dot11_bits",   32'(code_bits),      32'h00);

      // Dash threshold: 12 cycles is a dash
      mark_snap();
      drive(1'b1, 12);
      drive(1'b0, 16);
      chk("dash12_nvalid", 32'(valid_cnt - v0), 32'd1);
      chk("dash12_len",    32'(code_len),       32'd1);
      chk("dash12_bits",   32'(code_bits),      32'h01);

      // Six symbols overflow the buffer
      mark_snap();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 4);
         drive(1'b0, 4);
      end
      drive(1'b1, 4);
      drive(1'b0, 16);
      chk("ovf_npulse", 32'(ovf_cnt - o0),   32'd1);
      chk("ovf_nvalid", 32'(valid_cnt - v0), 32'd0);
      chk("ovf_len",    32'(code_len),       32'd1);
      chk("ovf_bits",   32'(code_bits),      32'h01);

      // Key returns exactly on the gap-completion tick
      mark_snap();
      drive(1'b1, 4);
      drive(1'b0, 12);
      drive(1'b1, 4);
      chk("race_none", 32'(valid_cnt - v0), 32'd0);
      drive(1'b0, 16);
      chk("race_nvalid", 32'(valid_cnt - v0), 32'd1);
      chk("race_len",    32'(code_len),       32'd2);
      chk("race_bits",   32'(code_bits),      32'h00);

      // Reset in the middle of a press
      mark_snap();
      drive(1'b1, 6);
      rst = 1'b1;
      drive(1'b1, 6);
      chk("rstm_len",  32'(code_len),  32'd0);
      chk("rstm_busy", 32'(busy),      32'd0);
      rst = 1'b0;
      drive(1'b0, 16);
      chk("rstm_nvalid", 32'(valid_cnt - v0), 32'd0);
      chk("rstm_novf",   32'(ovf_cnt - o0),   32'd0);
      chk("rstm_busy2",  32'(busy),           32'd0);
      mark_snap();
      drive(1'b1, 4);
      drive(1'b0, 4);
      drive(1'b1, 12);
      drive(1'b0, 16);
      chk("post_nvalid", 32'(valid_cnt - v0), 32'd1);
      chk("post_len",    32'(code_len),       32'd2);
      chk("post_bits",   32'(code_bits),      32'h02);

      // Long press saturates the duration counter and stays a dash
      mark_snap();
      drive(1'b1, 80);
      drive(1'b0, 16);
      chk("sat_nvalid", 32'(valid_cnt - v0), 32'd1);
      chk("sat_len",    32'(code_len),       32'd1);
      chk("sat_bits",   32'(code_bits),      32'h01);
      chk("sat_busy",   32'(busy),           32'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 Parameter TICK_DIV, default 10_000_000: clk cycles per timing tick (100 ms at 100 MHz).
REQ-002 Parameter DASH_MIN, default 3: mark lasting >= DASH_MIN ticks is a dash; otherwise it is a dot.
REQ-003 Parameter CHAR_GAP, default 3: space lasting CHAR_GAP ticks ends the character.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  reset; one clock, synchronous, active-high.
REQ-006 key  in  1  synchronised, debounced key level; 1 = pressed (mark).
REQ-007 code_valid  out  1  one-cycle pulse; a decoded character is on code_len/code_bits.
REQ-008 code_len  out  3  symbol count of the character, 1..5.
REQ-009 code_bits  out  5  bit i = symbol i (1 = dash, 0 = dot); first symbol at bit 0; bits >= code_len are 0.
REQ-010 overflow  out  1  one-cycle pulse; a character with more than 5 symbols was discarded.
REQ-011 busy  out  1  high whenever the state is not IDLE.

Function
REQ-012 FSM states are IDLE, MARK and SPACE; all outputs are registered.
REQ-013 The tick prescaler counts 0..TICK_DIV-1 and asserts tick in the cycle the count equals TICK_DIV-1.
REQ-014 The prescaler and the 3-bit duration counter clear on every state transition.
REQ-015 The duration counter increments on each tick and saturates at 7.
REQ-016 IDLE: key=1 -> MARK; key=0 -> stay in IDLE.
REQ-017 MARK: key=0 -> SPACE; the symbol is classified as dash if the duration count is >= DASH_MIN, else dot.
REQ-018 MARK exit: the symbol is written at bit index sym_cnt and sym_cnt increments.
REQ-019 MARK exit with sym_cnt already 5: no write; the sticky ovf flag is set for the current character.
REQ-020 SPACE: key=1 -> MARK; the character continues.
REQ-021 SPACE: on a tick where the duration count is CHAR_GAP-1 and key=0, the FSM goes to IDLE; the next cycle carries code_valid=1 (ovf clear) or overflow=1 (ovf set), never both.
REQ-022 Simultaneous gap completion and key=1 in the same cycle: key wins; the FSM goes to MARK and nothing is emitted.
REQ-023 code_len/code_bits update only on emission and hold their value until the next emission.
REQ-024 On emission, the symbol buffer, sym_cnt and ovf clear.
REQ-025 A mark shorter than one tick still counts as a dot; there is no minimum-width rejection (debounce is upstream).

Reset
REQ-026 While rst=1, the state is IDLE and all counters, buffers and ovf are 0.
REQ-027 While rst=1, code_valid=0, code_len=0, code_bits=0, overflow=0 and busy=0.
REQ-028 Reset mid-character discards the partial character with no pulse; after reset, the next key=1 starts a new character.

Structure
REQ-029 Package morse_pkg holds the state enum, MAX_SYM=5, the code_len width (3) and the code_bits width (5).
REQ-030 One sub-module, morse_tick_gen, holds the prescaler: parameter TICK_DIV, inputs clk, rst, clr; output tick.
REQ-031 All parameter-derived counter widths are computed with $clog2; there are no magic widths in the decoder.

Verification (TICK_DIV=4, DASH_MIN=3, CHAR_GAP=3)
REQ-032 Letter 'A': key high 4 cycles, low 4, high 12, low 12 -> exactly one code_valid with code_len=2, code_bits=5'b00010.
REQ-033 Dash threshold: key high 11 cycles then low 12 -> dot (code_bits=0, len=1); key high 12 cycles then low 12 -> dash (code_bits=1, len=1).
REQ-034 Overflow: six 4-cycle marks separated by 4-cycle spaces, then low 12 -> one overflow pulse, no code_valid, code_len/code_bits unchanged.
REQ-035 Gap race: key re-asserted on the exact gap-completion cycle -> no emission; a following dot and a 12-cycle gap -> code_len=2.
REQ-036 Reset mid-MARK: rst pulse during a 12-cycle press, then release -> no pulse, busy=0, and the next character decodes correctly.
REQ-037 Saturation: key high 80 cycles then low 12 -> dash, code_len=1, code_bits=5'b00001.
